// File: rtl/fp_exec_pkg.sv
// Shared types for the FP execution lane pipeline: FU classes, flag width,
// per-stage control word and the class-normalisation helper.
package fp_exec_pkg;

  localparam int unsigned FFLAGS_W = 5;
  localparam int unsigned CLASS_W  = 3;

  typedef enum logic [CLASS_W-1:0] {
    FU_ADD     = 3'd0,
    FU_MUL     = 3'd1,
    FU_FMA     = 3'd2,
    FU_DIVSQRT = 3'd3,
    FU_OTHER   = 3'd4
  } fu_class_e;

  typedef struct packed {
    logic      valid;
    logic      reg_valid;
    fu_class_e cls;
  } pipe_ctrl_t;

  // Codes beyond the implemented result classes fall back to OTHER.
  function automatic fu_class_e norm_class(input logic [CLASS_W-1:0] code,
                                           input int unsigned num_class);
    if (32'(code) >= num_class) return FU_OTHER;
    return fu_class_e'(code);
  endfunction

endpackage

// File: rtl/al_range_flush_detect.sv
// Combinational check of one active-list pointer against a flush range
// [head, tail) that may wrap around the pointer space.
module al_range_flush_detect #(
  parameter int unsigned ALP_W = 6
) (
  input  logic             flush_req,
  input  logic             flush_all,
  input  logic [ALP_W-1:0] head,
  input  logic [ALP_W-1:0] tail,
  input  logic [ALP_W-1:0] alp,
  output logic             flushed
);

  logic in_range;

  // head == tail takes the non-wrapped branch and yields an empty range.
  always_comb begin
    in_range = 1'b0;
    if (head <= tail) in_range = (alp >= head) && (alp < tail);
    else              in_range = (alp >= head) || (alp < tail);
  end

  assign flushed = flush_req & (flush_all | in_range);

endmodule

// File: rtl/fp_exec_lane_pipe.sv
// Multi-lane FP execution pipeline: carries op control/payload through DEPTH
// stages with selective flush, replay detection, div/sqrt handshake and result mux.
module fp_exec_lane_pipe
  import fp_exec_pkg::*;
#(
  parameter int unsigned LANES     = 2,
  parameter int unsigned DEPTH     = 3,
  parameter int unsigned DIV_LANES = 1,
  parameter int unsigned NUM_CLASS = 5,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned PAY_W     = 48,
  parameter int unsigned ALP_W     = 6
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          stall,
  input  logic                                          clear,
  input  logic [LANES-1:0]                              in_valid,
  input  logic [LANES-1:0]                              in_opnd_ok,
  input  logic [LANES-1:0][CLASS_W-1:0]                 in_class,
  input  logic [LANES-1:0]                              in_replay,
  input  logic [LANES-1:0][ALP_W-1:0]                   in_alp,
  input  logic [LANES-1:0][PAY_W-1:0]                   in_payload,
  input  logic                                          flush_req,
  input  logic                                          flush_all,
  input  logic [ALP_W-1:0]                              flush_head,
  input  logic [ALP_W-1:0]                              flush_tail,
  input  logic [LANES-1:0][NUM_CLASS-1:0][DATA_W-1:0]   fu_data,
  input  logic [LANES-1:0][NUM_CLASS-1:0][FFLAGS_W-1:0] fu_fflags,
  input  logic [DIV_LANES-1:0]                          div_reserved,
  input  logic [DIV_LANES-1:0]                          div_finished,
  output logic [DIV_LANES-1:0]                          div_req,
  output logic [DIV_LANES-1:0]                          div_release,
  output logic [LANES-1:0]                              out_valid,
  output logic [LANES-1:0]                              out_reg_valid,
  output logic [LANES-1:0][DATA_W-1:0]                  out_data,
  output logic [LANES-1:0][FFLAGS_W-1:0]                out_fflags,
  output logic [LANES-1:0][ALP_W-1:0]                   out_alp,
  output logic [LANES-1:0][PAY_W-1:0]                   out_payload,
  output logic [LANES-1:0]                              replay_valid,
  output logic [LANES-1:0][PAY_W-1:0]                   replay_payload,
  output logic [FFLAGS_W-1:0]                           fflags_acc,
  input  logic                                          fflags_clr
);

  typedef struct packed {
    pipe_ctrl_t       ctrl;
    logic [ALP_W-1:0] alp;
    logic [PAY_W-1:0] payload;
  } pipe_reg_t;

  pipe_reg_t                     stage_q  [DEPTH][LANES];
  pipe_reg_t                     stage_in [LANES];
  logic [DEPTH-1:0][LANES-1:0]   flushed;
  logic [FFLAGS_W-1:0]           delivered_flags;
  logic                          unused_replay;

  assign unused_replay = ^in_replay;

  for (genvar d = 0; d < DEPTH; d++) begin : g_stage
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      al_range_flush_detect #(.ALP_W(ALP_W)) u_flush (
        .flush_req (flush_req),
        .flush_all (flush_all),
        .head      (flush_head),
        .tail      (flush_tail),
        .alp       (stage_q[d][l].alp),
        .flushed   (flushed[d][l])
      );
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    fu_class_e           cls;
    logic                reg_valid;
    pipe_reg_t           last;
    pipe_reg_t           s1;
    logic [DATA_W-1:0]   data_sel;
    logic [FFLAGS_W-1:0] flags_sel;

    assign cls  = norm_class(in_class[l], NUM_CLASS);
    assign last = stage_q[DEPTH-1][l];
    assign s1   = stage_q[1][l];

    if (l < DIV_LANES) begin : g_div
      // A div op only has a result once the unit has finished, which is signalled on its replay issue.
      assign reg_valid = (cls == FU_DIVSQRT) ? (in_replay[l] & div_finished[l]) : in_opnd_ok[l];
      assign data_sel  = fu_data[l][last.ctrl.cls];
      assign flags_sel = fu_fflags[l][last.ctrl.cls];
      assign div_req[l] = ~rst & div_reserved[l] & in_valid[l] & (cls == FU_DIVSQRT) & in_opnd_ok[l];
      assign div_release[l] = div_finished[l] & last.ctrl.valid & last.ctrl.reg_valid
                              & (last.ctrl.cls == FU_DIVSQRT);
    end else begin : g_nodiv
      assign reg_valid = in_opnd_ok[l];
      assign data_sel  = (last.ctrl.cls == FU_DIVSQRT) ? '0 : fu_data[l][last.ctrl.cls];
      assign flags_sel = (last.ctrl.cls == FU_DIVSQRT) ? '0 : fu_fflags[l][last.ctrl.cls];
    end

    assign stage_in[l] = '{ctrl: '{valid: in_valid[l], reg_valid: reg_valid, cls: cls},
                           alp: in_alp[l], payload: in_payload[l]};

    assign out_valid[l]      = last.ctrl.valid & ~stall & ~clear & ~flushed[DEPTH-1][l];
    assign out_reg_valid[l]  = last.ctrl.valid & last.ctrl.reg_valid;
    assign out_data[l]       = rst ? '0 : data_sel;
    assign out_fflags[l]     = rst ? '0 : flags_sel;
    assign out_alp[l]        = last.alp;
    assign out_payload[l]    = last.payload;
    assign replay_valid[l]   = s1.ctrl.valid & ~s1.ctrl.reg_valid & ~stall & ~clear & ~flushed[1][l];
    assign replay_payload[l] = s1.payload;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned d = 0; d < DEPTH; d++)
        for (int unsigned l = 0; l < LANES; l++)
          stage_q[d][l] <= '0;
    end else if (clear) begin
      for (int unsigned d = 0; d < DEPTH; d++)
        for (int unsigned l = 0; l < LANES; l++) begin
          stage_q[d][l].ctrl.valid     <= 1'b0;
          stage_q[d][l].ctrl.reg_valid <= 1'b0;
        end
    end else if (!stall) begin
      for (int unsigned l = 0; l < LANES; l++)
        stage_q[0][l] <= stage_in[l];
      // Whole word advances; the valid bit is then overridden by the flush check of the source stage.
      for (int unsigned d = 1; d < DEPTH; d++)
        for (int unsigned l = 0; l < LANES; l++) begin
          stage_q[d][l]            <= stage_q[d-1][l];
          stage_q[d][l].ctrl.valid <= stage_q[d-1][l].ctrl.valid & ~flushed[d-1][l];
        end
    end
  end

  always_comb begin
    delivered_flags = '0;
    for (int unsigned l = 0; l < LANES; l++)
      if (out_valid[l] && out_reg_valid[l]) delivered_flags |= out_fflags[l];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             fflags_acc <= '0;
    else if (fflags_clr) fflags_acc <= '0;
    else                 fflags_acc <= fflags_acc | delivered_flags;
  end

endmodule

// File: tb/tb_fp_exec_lane_pipe.sv
// Directed bench for fp_exec_lane_pipe (LANES=2, DEPTH=3, one div lane):
// latency, stall, wrap-around flush, replay, div handshake, class mux and sticky flags.
module tb_fp_exec_lane_pipe;
  import fp_exec_pkg::*;

  localparam int unsigned LANES = 2, DEPTH = 3, DIV_LANES = 1, NUM_CLASS = 5;
  localparam int unsigned DATA_W = 64, PAY_W = 48, ALP_W = 6;

  logic clk = 1'b0, rst, stall, clear, flush_req, flush_all, fflags_clr;
  logic [LANES-1:0] in_valid, in_opnd_ok, in_replay;
  logic [LANES-1:0][2:0] in_class;
  logic [LANES-1:0][ALP_W-1:0] in_alp;
  logic [LANES-1:0][PAY_W-1:0] in_payload;
  logic [ALP_W-1:0] flush_head, flush_tail;
  logic [LANES-1:0][NUM_CLASS-1:0][DATA_W-1:0] fu_data;
  logic [LANES-1:0][NUM_CLASS-1:0][4:0] fu_fflags;
  logic [DIV_LANES-1:0] div_reserved, div_finished, div_req, div_release;
  logic [LANES-1:0] out_valid, out_reg_valid, replay_valid;
  logic [LANES-1:0][DATA_W-1:0] out_data;
  logic [LANES-1:0][4:0] out_fflags;
  logic [LANES-1:0][ALP_W-1:0] out_alp;
  logic [LANES-1:0][PAY_W-1:0] out_payload, replay_payload;
  logic [4:0] fflags_acc;

  int compares = 0;
  int mismatches = 0;

  fp_exec_lane_pipe #(
    .LANES(LANES), .DEPTH(DEPTH), .DIV_LANES(DIV_LANES), .NUM_CLASS(NUM_CLASS),
    .DATA_W(DATA_W), .PAY_W(PAY_W), .ALP_W(ALP_W)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .clear(clear),
    .in_valid(in_valid), .in_opnd_ok(in_opnd_ok), .in_class(in_class),
    .in_replay(in_replay), .in_alp(in_alp), .in_payload(in_payload),
    .flush_req(flush_req), .flush_all(flush_all), .flush_head(flush_head), .flush_tail(flush_tail),
    .fu_data(fu_data), .fu_fflags(fu_fflags),
    .div_reserved(div_reserved), .div_finished(div_finished),
    .div_req(div_req), .div_release(div_release),
    .out_valid(out_valid), .out_reg_valid(out_reg_valid), .out_data(out_data),
    .out_fflags(out_fflags), .out_alp(out_alp), .out_payload(out_payload),
    .replay_valid(replay_valid), .replay_payload(replay_payload),
    .fflags_acc(fflags_acc), .fflags_clr(fflags_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compares++;
    assert (obs === exp) else begin
      mismatches++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    in_valid = '0; in_opnd_ok = '0; in_class = '0; in_replay = '0;
    in_alp = '0; in_payload = '0; div_reserved = '0;
  endtask

  task automatic issue(input int unsigned l, input logic [2:0] c, input logic [ALP_W-1:0] alp,
                       input logic [PAY_W-1:0] pay, input logic ok, input logic rep);
    in_valid[l] = 1'b1; in_class[l] = c; in_alp[l] = alp;
    in_payload[l] = pay; in_opnd_ok[l] = ok; in_replay[l] = rep;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; clear = 1'b0; flush_req = 1'b0; flush_all = 1'b0;
    flush_head = '0; flush_tail = '0; fflags_clr = 1'b0; div_finished = '0;
    idle();
    fu_fflags = '0;
    for (int l = 0; l < 2; l++)
      for (int c = 0; c < 5; c++)
        fu_data[l][c] = 64'hC0DE_0000_0000_0000 | (64'(l) << 16) | 64'(c + 1);

    // outputs must stay quiet in reset even with live inputs
    issue(0, 3'd3, 6'd1, 48'h1, 1'b1, 1'b0);
    issue(1, 3'd0, 6'd2, 48'h2, 1'b1, 1'b0);
    div_reserved = 1'b1;
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data0", out_data[0], 64'h0);
    chk("rst_out_data1", out_data[1], 64'h0);
    chk("rst_div_req", 64'(div_req), 64'h0);
    chk("rst_fflags_acc", 64'(fflags_acc), 64'h0);
    tick();
    rst = 1'b0;
    idle();

    // basic latency: ADD on lane 0
    issue(0, 3'd0, 6'd5, 48'hAAAA_0000_0001, 1'b1, 1'b0);
    tick(); idle();
    chk("lat_c1_valid", 64'(out_valid), 64'h0);
    tick();
    chk("lat_c2_valid", 64'(out_valid), 64'h0);
    tick();
    chk("lat_c3_valid", 64'(out_valid), 64'h1);
    chk("lat_data", out_data[0], 64'hC0DE_0000_0000_0001);
    chk("lat_payload", 64'(out_payload[0]), 64'hAAAA_0000_0001);
    chk("lat_alp", 64'(out_alp[0]), 64'd5);
    chk("lat_reg_valid", 64'(out_reg_valid), 64'h1);
    tick();
    chk("lat_c4_valid", 64'(out_valid), 64'h0);

    // two-cycle stall while the op sits in stage 1
    issue(1, 3'd1, 6'd7, 48'hBBBB_0000_0002, 1'b1, 1'b0);
    tick(); idle();
    tick();
    stall = 1'b1;
    tick();
    chk("stall_c3_valid", 64'(out_valid), 64'h0);
    tick();
    chk("stall_c4_valid", 64'(out_valid), 64'h0);
    stall = 1'b0;
    tick();
    chk("stall_c5_valid", 64'(out_valid), 64'h2);
    chk("stall_payload", 64'(out_payload[1]), 64'hBBBB_0000_0002);
    chk("stall_data", out_data[1], 64'hC0DE_0000_0001_0002);
    tick();

    // wrap-around flush head=60 tail=3
    issue(0, 3'd0, 6'd62, 48'h0000_0000_00A1, 1'b1, 1'b0);
    issue(1, 3'd0, 6'd3,  48'h0000_0000_00B2, 1'b1, 1'b0);
    tick();
    issue(0, 3'd0, 6'd1,  48'h0000_0000_00C3, 1'b1, 1'b0);
    issue(1, 3'd0, 6'd59, 48'h0000_0000_00D4, 1'b1, 1'b0);
    tick(); idle();
    flush_req = 1'b1; flush_head = 6'd60; flush_tail = 6'd3;
    tick();
    flush_req = 1'b0;
    #1;
    chk("flush_a_valid", 64'(out_valid), 64'h2);
    chk("flush_a_alp", 64'(out_alp[1]), 64'd3);
    chk("flush_a_payload", 64'(out_payload[1]), 64'hB2);
    tick();
    chk("flush_b_valid", 64'(out_valid), 64'h2);
    chk("flush_b_alp", 64'(out_alp[1]), 64'd59);
    chk("flush_b_payload", 64'(out_payload[1]), 64'hD4);
    flush_req = 1'b1; flush_head = 6'd59; flush_tail = 6'd59;
    #1;
    chk("flush_empty_range", 64'(out_valid), 64'h2);
    flush_tail = 6'd60;
    #1;
    chk("flush_last_gate", 64'(out_valid), 64'h0);
    flush_all = 1'b1; flush_tail = 6'd59;
    #1;
    chk("flush_all_gate", 64'(out_valid), 64'h0);
    flush_req = 1'b0; flush_all = 1'b0;
    tick();

    // operand not ready -> replay request from stage 1
    issue(1, 3'd0, 6'd9, 48'h5555_0000_0009, 1'b0, 1'b0);
    tick(); idle();
    chk("replay_c1", 64'(replay_valid), 64'h0);
    tick();
    chk("replay_c2", 64'(replay_valid), 64'h2);
    chk("replay_payload", 64'(replay_payload[1]), 64'h5555_0000_0009);
    tick();
    chk("replay_c3", 64'(replay_valid), 64'h0);
    chk("replay_out_valid", 64'(out_valid), 64'h2);
    chk("replay_out_regv", 64'(out_reg_valid), 64'h0);
    tick();

    // div op on its replay issue with the unit finished
    issue(0, 3'd3, 6'd10, 48'h0000_0000_0D10, 1'b1, 1'b1);
    div_finished = 1'b1; div_reserved = 1'b1;
    #1;
    chk("div_req_on", 64'(div_req), 64'h1);
    tick(); idle();
    div_finished = 1'b0;
    #1;
    chk("div_req_off", 64'(div_req), 64'h0);
    tick(); tick();
    chk("div_out_valid", 64'(out_valid), 64'h1);
    chk("div_out_regv", 64'(out_reg_valid), 64'h1);
    chk("div_out_data", out_data[0], 64'hC0DE_0000_0000_0004);
    chk("div_rel_wait", 64'(div_release), 64'h0);
    div_finished = 1'b1;
    #1;
    chk("div_rel_on", 64'(div_release), 64'h1);
    div_finished = 1'b0;
    tick();

    // flushed div op must not release the unit
    issue(0, 3'd3, 6'd20, 48'h0000_0000_0D20, 1'b1, 1'b1);
    div_finished = 1'b1;
    tick(); idle();
    div_finished = 1'b0;
    flush_req = 1'b1; flush_head = 6'd20; flush_tail = 6'd21;
    tick();
    flush_req = 1'b0;
    tick();
    div_finished = 1'b1;
    #1;
    chk("div_flush_rel", 64'(div_release), 64'h0);
    chk("div_flush_valid", 64'(out_valid), 64'h0);
    div_finished = 1'b0;

    // invalid class -> OTHER; DIVSQRT on a non-div lane -> zero data
    issue(0, 3'd7, 6'd30, 48'h30, 1'b1, 1'b0);
    issue(1, 3'd3, 6'd31, 48'h31, 1'b1, 1'b0);
    tick(); idle();
    tick(); tick();
    chk("cls_valid", 64'(out_valid), 64'h3);
    chk("cls_other_data", out_data[0], 64'hC0DE_0000_0000_0005);
    chk("cls_nodiv_data", out_data[1], 64'h0);
    tick();

    // sticky fflags accumulation and clear priority
    chk("ff_start", 64'(fflags_acc), 64'h0);
    fu_fflags[0][0] = 5'h01;
    fu_fflags[1][1] = 5'h10;
    issue(0, 3'd0, 6'd40, 48'h40, 1'b1, 1'b0);
    tick(); idle();
    tick(); tick();
    chk("ff_out0", 64'(out_fflags[0]), 64'h01);
    tick();
    chk("ff_acc1", 64'(fflags_acc), 64'h01);
    issue(1, 3'd1, 6'd41, 48'h41, 1'b1, 1'b0);
    tick(); idle();
    tick(); tick();
    chk("ff_out1", 64'(out_fflags[1]), 64'h10);
    tick();
    chk("ff_acc2", 64'(fflags_acc), 64'h11);
    issue(0, 3'd0, 6'd42, 48'h42, 1'b1, 1'b0);
    tick(); idle();
    tick(); tick();
    chk("ff_clr_deliver", 64'(out_valid), 64'h1);
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    chk("ff_clr_wins", 64'(fflags_acc), 64'h0);

    // clear overrides stall and empties the pipe
    issue(0, 3'd0, 6'd50, 48'h50, 1'b0, 1'b0);
    tick(); idle();
    clear = 1'b1; stall = 1'b1;
    tick();
    clear = 1'b0; stall = 1'b0;
    tick();
    chk("clr_replay", 64'(replay_valid), 64'h0);
    tick();
    chk("clr_out_valid", 64'(out_valid), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end

endmodule
